// File: rtl/hrnode_pkg.sv
// hrnode_pkg
//   Shared definitions for the hierarchical-ring node: flit width, field
//   offsets, the flit type, the per-lane slot decision and small field
//   helpers.
//   Flit layout: [0] valid, [3:1] reserved, [7:4] dst, [11:8] src,
//                [15:12] hop count, [143:16] payload. An invalid flit is all zeros.
package hrnode_pkg;

    localparam int unsigned FLIT_W  = 144;
    localparam int unsigned VALID_B = 0;
    localparam int unsigned DST_LO  = 4;
    localparam int unsigned DST_HI  = 7;
    localparam int unsigned SRC_LO  = 8;
    localparam int unsigned SRC_HI  = 11;
    localparam int unsigned HOP_LO  = 12;
    localparam int unsigned HOP_HI  = 15;

    typedef logic [FLIT_W-1:0] flit_t;

    // What the upstream ring flit does with this node's slot this cycle.
    typedef enum logic [1:0] {
        LANE_FREE  = 2'd0,   // no ring flit: slot available for injection
        LANE_PASS  = 2'd1,   // ring flit continues downstream
        LANE_EJECT = 2'd2    // ring flit leaves here; slot freed
    } lane_act_e;

    function automatic logic is_valid(input flit_t f);
        return f[VALID_B];
    endfunction

    function automatic logic [3:0] dst_of(input flit_t f);
        return f[DST_HI:DST_LO];
    endfunction

    function automatic logic [3:0] hop_of(input flit_t f);
        return f[HOP_HI:HOP_LO];
    endfunction

    function automatic flit_t set_hop(input flit_t f, input logic [3:0] hop);
        flit_t r;
        r = f;
        r[HOP_HI:HOP_LO] = hop;
        return r;
    endfunction

endpackage

// File: rtl/hrnode_lane.sv
// hrnode_lane
//   One lane of the ring stop: decides eject / forward / inject for the
//   upstream flit, registers the downstream and ejected flits, and
//   acknowledges local injection combinationally.
//   Optional feature macro: HRNODE_HOPCNT_EN (forwarded flits get their hop
//   count incremented with saturation; injected flits leave with hop=0).
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous reset, active-low
//   ring_i   in   144  upstream ring flit
//   local_i  in   144  local injection flit
//   ring_o   out  144  downstream ring flit, registered
//   local_o  out  144  ejected flit, registered
//   ack      out  1    local_i accepted this cycle (combinational)
module hrnode_lane
    import hrnode_pkg::*;
#(
    parameter logic [3:0] addr = 4'b0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] ring_i,
    input  logic [FLIT_W-1:0] local_i,
    output logic [FLIT_W-1:0] ring_o,
    output logic [FLIT_W-1:0] local_o,
    output logic              ack
);

    lane_act_e act;
    flit_t     fwd_flit;
    flit_t     inj_flit;
    logic      local_vld;

    always_comb begin
        act = LANE_FREE;
        if (is_valid(ring_i)) begin
            act = (dst_of(ring_i) == addr) ? LANE_EJECT : LANE_PASS;
        end
    end

`ifdef HRNODE_HOPCNT_EN
    always_comb begin
        fwd_flit = set_hop(ring_i, (hop_of(ring_i) == 4'hF) ? 4'hF : hop_of(ring_i) + 4'd1);
        inj_flit = set_hop(local_i, 4'h0);
    end
`else
    always_comb begin
        fwd_flit = ring_i;
        inj_flit = local_i;
    end
`endif

    assign local_vld = is_valid(local_i);

    // An ejected flit frees the slot in the same cycle, so injection only
    // loses to a flit that is actually passing through.
    assign ack = rst && local_vld && (act != LANE_PASS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ring_o  <= '0;
            local_o <= '0;
        end else begin
            case (act)
                LANE_PASS: begin
                    ring_o  <= fwd_flit;
                    local_o <= '0;
                end
                LANE_EJECT: begin
                    ring_o  <= local_vld ? inj_flit : '0;
                    local_o <= ring_i;
                end
                default: begin
                    ring_o  <= local_vld ? inj_flit : '0;
                    local_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hrnode_ring_stop.sv
// hrnode_ring_stop
//   Ring stop for a hierarchical-ring NoC serving two independent
//   unidirectional rings (lane 0, lane 1). Per lane: eject flits addressed
//   to this node, forward others, inject a local flit into any free slot.
//   Optional feature macro: HRNODE_HOPCNT_EN (hop counting on forwarded flits).
// Ports
//   clk            in   1    rising-edge clock
//   rst            in   1    synchronous reset, active-low
//   port0_i        in   144  ring-0 upstream flit
//   port1_i        in   144  ring-1 upstream flit
//   port0_local_i  in   144  local injection flit for ring 0
//   port1_local_i  in   144  local injection flit for ring 1
//   port0_o        out  144  ring-0 downstream flit, registered
//   port1_o        out  144  ring-1 downstream flit, registered
//   port0_local_o  out  144  ring-0 ejected flit, registered
//   port1_local_o  out  144  ring-1 ejected flit, registered
//   portl0_ack     out  1    port0_local_i accepted this cycle
//   portl1_ack     out  1    port1_local_i accepted this cycle
module hrnode_ring_stop
    import hrnode_pkg::*;
#(
    parameter logic [3:0] addr = 4'b0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] port0_i,
    input  logic [FLIT_W-1:0] port1_i,
    input  logic [FLIT_W-1:0] port0_local_i,
    input  logic [FLIT_W-1:0] port1_local_i,
    output logic [FLIT_W-1:0] port0_o,
    output logic [FLIT_W-1:0] port1_o,
    output logic [FLIT_W-1:0] port0_local_o,
    output logic [FLIT_W-1:0] port1_local_o,
    output logic              portl0_ack,
    output logic              portl1_ack
);

    hrnode_lane #(.addr(addr)) u_lane0 (
        .clk     (clk),
        .rst     (rst),
        .ring_i  (port0_i),
        .local_i (port0_local_i),
        .ring_o  (port0_o),
        .local_o (port0_local_o),
        .ack     (portl0_ack)
    );

    hrnode_lane #(.addr(addr)) u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .ring_i  (port1_i),
        .local_i (port1_local_i),
        .ring_o  (port1_o),
        .local_o (port1_local_o),
        .ack     (portl1_ack)
    );

endmodule

// File: tb/tb_hrnode_ring_stop.sv
module tb_hrnode_ring_stop;
    import hrnode_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    flit_t port0_i = '0, port1_i = '0, port0_local_i = '0, port1_local_i = '0;
    flit_t port0_o, port1_o, port0_local_o, port1_local_o;
    logic  portl0_ack, portl1_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hrnode_ring_stop #(.addr(4'b0010)) dut (
        .clk           (clk),
        .rst           (rst),
        .port0_i       (port0_i),
        .port1_i       (port1_i),
        .port0_local_i (port0_local_i),
        .port1_local_i (port1_local_i),
        .port0_o       (port0_o),
        .port1_o       (port1_o),
        .port0_local_o (port0_local_o),
        .port1_local_o (port1_local_o),
        .portl0_ack    (portl0_ack),
        .portl1_ack    (portl1_ack)
    );

    // Hand-built flits (addr = 2).
    localparam flit_t F_A  = 144'h0123456789abcdef0123456789abcdef1851; // dst5 src8 hop1
    localparam flit_t F_E  = 144'h0000beef00000021;                     // dst2 (ejects)
    localparam flit_t F_L  = 144'h55550051;                             // local, dst5 hop0
    localparam flit_t F_LS = 144'h77770021;                             // local, dst2 hop0
    localparam flit_t F_H  = 144'h9F351;                                // dst5 src3 hopF
    localparam flit_t F_R  = 144'h1234003F;                             // dst3 reserved=111 hop0
    localparam flit_t F_LH = 144'hABCD3051;                             // local, dst5 hop3
`ifdef HRNODE_HOPCNT_EN
    localparam flit_t F_A_FWD  = 144'h0123456789abcdef0123456789abcdef2851;
    localparam flit_t F_R_FWD  = 144'h1234103F;
    localparam flit_t F_LH_INJ = 144'hABCD0051;
`else
    localparam flit_t F_A_FWD  = F_A;
    localparam flit_t F_R_FWD  = F_R;
    localparam flit_t F_LH_INJ = F_LH;
`endif

    typedef struct {
        int    id;
        logic  a0, a1;
        flit_t p0, p1, l0, l1;
    } exp_t;

    exp_t sb[$];

    task automatic chk_bit(input int id, input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %b expected %b", id, nm, act, exp);
        end
    endtask

    task automatic chk_flit(input int id, input string nm, input flit_t act, input flit_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Monitor: acks are sampled while the step's inputs are still applied,
    // registered outputs just after the edge that captures them.
    initial begin
        exp_t e;
        logic a0, a1;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                a0 = portl0_ack;
                a1 = portl1_ack;
                #1;
                chk_bit (e.id, "portl0_ack",    a0,            e.a0);
                chk_bit (e.id, "portl1_ack",    a1,            e.a1);
                chk_flit(e.id, "port0_o",       port0_o,       e.p0);
                chk_flit(e.id, "port1_o",       port1_o,       e.p1);
                chk_flit(e.id, "port0_local_o", port0_local_o, e.l0);
                chk_flit(e.id, "port1_local_o", port1_local_o, e.l1);
            end
        end
    end

    int step_id = 0;

    task automatic step(input logic r, input flit_t p0, input flit_t p1,
                        input flit_t l0, input flit_t l1,
                        input logic ea0, input logic ea1,
                        input flit_t ep0, input flit_t ep1,
                        input flit_t el0, input flit_t el1);
        exp_t e;
        @(negedge clk);
        rst = r;
        port0_i = p0;
        port1_i = p1;
        port0_local_i = l0;
        port1_local_i = l1;
        step_id++;
        e.id = step_id; e.a0 = ea0; e.a1 = ea1;
        e.p0 = ep0; e.p1 = ep1; e.l0 = el0; e.l1 = el1;
        sb.push_back(e);
    endtask

    initial begin
        //    rst  p0   p1    l0    l1     a0 a1  p0_o     p1_o     l0_o l1_o
        step(0, F_A, '0,   '0,   '0,    0, 0,  '0,      '0,      '0,  '0);   // reset clears
        step(0, '0,  '0,   F_L,  F_L,   0, 0,  '0,      '0,      '0,  '0);   // acks held low in reset
        step(1, F_A, '0,   '0,   '0,    0, 0,  F_A_FWD, '0,      '0,  '0);   // forward lane 0
        step(1, '0,  F_E,  '0,   '0,    0, 0,  '0,      '0,      '0,  F_E);  // eject lane 1
        step(1, F_A, '0,   F_L,  '0,    0, 0,  F_A_FWD, '0,      '0,  '0);   // ring beats inject
        step(1, '0,  '0,   F_L,  '0,    1, 0,  F_L,     '0,      '0,  '0);   // held flit now injects
        step(1, '0,  F_E,  '0,   F_L,   0, 1,  '0,      F_L,     '0,  F_E);  // eject+inject same lane
        step(1, F_H, F_A,  '0,   '0,    0, 0,  F_H,     F_A_FWD, '0,  '0);   // hop F stays F
        step(1, '0,  '0,   F_LS, F_LS,  1, 1,  F_LS,    F_LS,    '0,  '0);   // no local loopback
        step(1, '0,  F_R,  '0,   F_L,   0, 0,  '0,      F_R_FWD, '0,  '0);   // reserved bits kept
        step(1, '0,  '0,   F_LH, '0,    1, 0,  F_LH_INJ,'0,      '0,  '0);   // injected hop field
        step(1, F_E, F_E,  '0,   '0,    0, 0,  '0,      '0,      F_E, F_E);  // eject both lanes
        step(1, '0,  '0,   '0,   '0,    0, 0,  '0,      '0,      '0,  '0);   // idle
        step(1, F_E, F_A,  '0,   '0,    0, 0,  '0,      F_A_FWD, F_E, '0);
        step(0, F_E, F_A,  F_L,  F_L,   0, 0,  '0,      '0,      '0,  '0);   // mid-op reset

        @(negedge clk);
        rst = 1'b1;
        port0_i = '0; port1_i = '0; port0_local_i = '0; port1_local_i = '0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
